// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared types and widths for the PIFO access controller
package pifo_pkg;

    localparam int PIFO_PRIO_W = 8;
    localparam int PIFO_DATA_W = 8;

    typedef enum logic {
        T_ENQ = 1'b0,
        T_DEQ = 1'b1
    } turn_t;

    typedef struct packed {
        logic [PIFO_DATA_W-1:0] data;
        logic [PIFO_PRIO_W-1:0] prio;
    } pifo_entry_t;

    function automatic turn_t other_side(input turn_t t);
        return (t == T_ENQ) ? T_DEQ : T_ENQ;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant from a supplied start pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    int               k;
    logic             found;
    logic [IDX_W-1:0] idx;

    // Scan ports starting at ptr, wrapping modulo N; the first requester wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            idx = IDX_W'(k);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pifo_access_ctrl.sv
// rtl/pifo_access_ctrl.sv - enqueue arbitration and push/pop turn scheduling in front of pifo_base
module pifo_access_ctrl
    import pifo_pkg::*;
#(
    parameter int NUM_ENQ_PORTS = 4,
    parameter int PRIO_WIDTH    = PIFO_PRIO_W,
    parameter int DATA_WIDTH    = PIFO_DATA_W,
    parameter int BURST_MAX     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i__clear_all,
    input  logic [NUM_ENQ_PORTS-1:0]         i__enq_valid,
    input  logic [NUM_ENQ_PORTS*PRIO_WIDTH-1:0] i__enq_prio,
    input  logic [NUM_ENQ_PORTS*DATA_WIDTH-1:0] i__enq_data,
    output logic [NUM_ENQ_PORTS-1:0]         o__enq_ready,
    output logic                             o__deq_valid,
    output logic [PRIO_WIDTH-1:0]            o__deq_prio,
    output logic [DATA_WIDTH-1:0]            o__deq_data,
    input  logic                             i__deq_ready,
    output logic                             o__pifo_in_valid,
    output logic [PRIO_WIDTH-1:0]            o__pifo_in_prio,
    output logic [DATA_WIDTH-1:0]            o__pifo_in_data,
    input  logic                             i__pifo_in_ready,
    input  logic                             i__pifo_out_valid,
    input  logic [PRIO_WIDTH-1:0]            i__pifo_out_prio,
    input  logic [DATA_WIDTH-1:0]            i__pifo_out_data,
    output logic                             o__pifo_out_ready,
    output logic                             o__pifo_clear
);

    localparam int IDX_W = $clog2(NUM_ENQ_PORTS);
    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0] LAST_PORT  = IDX_W'(NUM_ENQ_PORTS - 1);

    pifo_entry_t        hold;
    logic               hold_valid;
    turn_t              turn, turn_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_nxt;
    logic [IDX_W-1:0]   rr_ptr;

    logic [NUM_ENQ_PORTS-1:0] arb_gnt;
    logic [IDX_W-1:0]         arb_idx;

    logic enq_pend, deq_block, deq_valid, pop, push, can_accept, accept;
    logic contended, owner_grant, owner_yield;

    rr_arbiter #(.N(NUM_ENQ_PORTS)) u_rr_arbiter (
        .req     (i__enq_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Push/pop exclusion: a pending push blocks the head only while enqueue owns the turn
    always_comb begin
        enq_pend   = hold_valid & i__pifo_in_ready & ~i__clear_all & ~reset;
        deq_block  = enq_pend & (turn == T_ENQ);
        deq_valid  = i__pifo_out_valid & ~deq_block & ~i__clear_all & ~reset;
        pop        = deq_valid & i__deq_ready;
        push       = enq_pend & ~pop;
        can_accept = (~hold_valid | push) & ~i__clear_all & ~reset;
        accept     = can_accept & (|i__enq_valid);
    end

    // Turn FSM next state: bounded bursts under contention, hand over when the owner idles
    always_comb begin
        turn_nxt    = turn;
        burst_nxt   = burst_cnt;
        contended   = enq_pend & i__pifo_out_valid;
        owner_grant = (turn == T_ENQ) ? push : pop;
        owner_yield = (turn == T_ENQ) ? (~enq_pend & pop) : push;
        if (i__clear_all) begin
            turn_nxt  = T_ENQ;
            burst_nxt = '0;
        end else if (contended && owner_grant) begin
            if (burst_cnt == BURST_LAST) begin
                turn_nxt  = other_side(turn);
                burst_nxt = '0;
            end else begin
                burst_nxt = burst_cnt + 1'b1;
            end
        end else if (owner_yield) begin
            turn_nxt  = other_side(turn);
            burst_nxt = '0;
        end
    end

    // State registers: holding entry, round-robin pointer, turn and burst count
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold       <= '0;
            turn       <= T_ENQ;
            burst_cnt  <= '0;
            rr_ptr     <= '0;
        end else begin
            turn      <= turn_nxt;
            burst_cnt <= burst_nxt;
            if (i__clear_all) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold.prio  <= i__enq_prio[arb_idx*PRIO_WIDTH +: PRIO_WIDTH];
                hold.data  <= i__enq_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr     <= (arb_idx == LAST_PORT) ? '0 : arb_idx + 1'b1;
            end else if (push) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign o__enq_ready      = arb_gnt & {NUM_ENQ_PORTS{can_accept}};
    assign o__deq_valid      = deq_valid;
    assign o__deq_prio       = reset ? '0 : i__pifo_out_prio;
    assign o__deq_data       = reset ? '0 : i__pifo_out_data;
    assign o__pifo_out_ready = pop;
    assign o__pifo_in_valid  = push;
    assign o__pifo_in_prio   = reset ? '0 : hold.prio;
    assign o__pifo_in_data   = reset ? '0 : hold.data;
    assign o__pifo_clear     = i__clear_all & ~reset;

endmodule

// File: tb/tb_pifo_access_ctrl.sv
// tb/tb_pifo_access_ctrl.sv - directed scoreboard bench for pifo_access_ctrl
module tb_pifo_access_ctrl;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear_all;
    logic [N-1:0]    enq_valid;
    logic [N*PW-1:0] enq_prio;
    logic [N*DW-1:0] enq_data;
    logic [N-1:0]    enq_ready;
    logic            deq_valid;
    logic [PW-1:0]   deq_prio;
    logic [DW-1:0]   deq_data;
    logic            deq_ready;
    logic            pifo_in_valid;
    logic [PW-1:0]   pifo_in_prio;
    logic [DW-1:0]   pifo_in_data;
    logic            pifo_in_ready;
    logic            pifo_out_valid;
    logic [PW-1:0]   pifo_out_prio;
    logic [DW-1:0]   pifo_out_data;
    logic            pifo_out_ready;
    logic            pifo_clear;

    logic [PW-1:0] p_prio [N];
    logic [DW-1:0] p_data [N];

    logic          env_model;
    logic          drv_in_ready, drv_out_valid;
    logic [PW-1:0] drv_out_prio;
    logic [DW-1:0] drv_out_data;

    logic [PW-1:0] m_prio [8] = '{default: '0};
    logic [DW-1:0] m_data [8] = '{default: '0};
    int            m_cnt = 0;

    int            n_vec = 0;
    int            n_err = 0;
    logic          sb_en = 1'b0;
    logic [15:0]   exp_push [$];
    logic [15:0]   exp_deq  [$];

    always #5 clk = ~clk;

    for (genvar p = 0; p < N; p++) begin : g_pack
        assign enq_prio[p*PW +: PW] = p_prio[p];
        assign enq_data[p*DW +: DW] = p_data[p];
    end

    assign pifo_in_ready  = env_model ? (m_cnt < 8)  : drv_in_ready;
    assign pifo_out_valid = env_model ? (m_cnt != 0) : drv_out_valid;
    assign pifo_out_prio  = env_model ? m_prio[0]    : drv_out_prio;
    assign pifo_out_data  = env_model ? m_data[0]    : drv_out_data;

    pifo_access_ctrl #(
        .NUM_ENQ_PORTS(N), .PRIO_WIDTH(PW), .DATA_WIDTH(DW), .BURST_MAX(4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i__clear_all      (clear_all),
        .i__enq_valid      (enq_valid),
        .i__enq_prio       (enq_prio),
        .i__enq_data       (enq_data),
        .o__enq_ready      (enq_ready),
        .o__deq_valid      (deq_valid),
        .o__deq_prio       (deq_prio),
        .o__deq_data       (deq_data),
        .i__deq_ready      (deq_ready),
        .o__pifo_in_valid  (pifo_in_valid),
        .o__pifo_in_prio   (pifo_in_prio),
        .o__pifo_in_data   (pifo_in_data),
        .i__pifo_in_ready  (pifo_in_ready),
        .i__pifo_out_valid (pifo_out_valid),
        .i__pifo_out_prio  (pifo_out_prio),
        .i__pifo_out_data  (pifo_out_data),
        .o__pifo_out_ready (pifo_out_ready),
        .o__pifo_clear     (pifo_clear)
    );

    // Behavioural PIFO: sorted by descending priority, ties kept in arrival order
    always @(posedge clk) begin : pifo_env
        logic [PW-1:0] tp [8];
        logic [DW-1:0] td [8];
        int            tc;
        int            j;
        tp = m_prio;
        td = m_data;
        tc = m_cnt;
        if (reset || pifo_clear) begin
            tc = 0;
        end else begin
            if (pifo_out_ready && tc > 0) begin
                for (int i = 0; i < 7; i++) begin
                    tp[i] = tp[i+1];
                    td[i] = td[i+1];
                end
                tc = tc - 1;
            end
            if (pifo_in_valid && tc < 8) begin
                j = tc;
                while (j > 0 && tp[j-1] < pifo_in_prio) begin
                    tp[j] = tp[j-1];
                    td[j] = td[j-1];
                    j = j - 1;
                end
                tp[j] = pifo_in_prio;
                td[j] = pifo_in_data;
                tc = tc + 1;
            end
        end
        m_prio <= tp;
        m_data <= td;
        m_cnt  <= tc;
    end

    // Scoreboard: every push and every consumer handshake must match the queued expectation
    always @(negedge clk) begin
        if (sb_en && !reset) begin
            if (pifo_in_valid) begin
                n_vec++;
                if (exp_push.size() == 0) begin
                    n_err++;
                    $error("FAIL push_unexpected: observed %0h expected none", {pifo_in_prio, pifo_in_data});
                end else begin
                    assert ({pifo_in_prio, pifo_in_data} === exp_push[0]) else begin
                        n_err++;
                        $error("FAIL push_entry: observed %0h expected %0h", {pifo_in_prio, pifo_in_data}, exp_push[0]);
                    end
                    void'(exp_push.pop_front());
                end
            end
            if (deq_valid && deq_ready) begin
                n_vec++;
                if (exp_deq.size() == 0) begin
                    n_err++;
                    $error("FAIL deq_unexpected: observed %0h expected none", {deq_prio, deq_data});
                end else begin
                    assert ({deq_prio, deq_data} === exp_deq[0]) else begin
                        n_err++;
                        $error("FAIL deq_entry: observed %0h expected %0h", {deq_prio, deq_data}, exp_deq[0]);
                    end
                    void'(exp_deq.pop_front());
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear_all = 1'b0; sb_en = 1'b0;
        env_model = 1'b0; drv_in_ready = 1'b1; drv_out_valid = 1'b1;
        drv_out_prio = 8'h5A; drv_out_data = 8'hA5;
        deq_ready = 1'b1; enq_valid = '1;
        for (int p = 0; p < N; p++) begin
            p_prio[p] = 8'(8'h10 + p);
            p_data[p] = 8'(8'hA0 + p);
        end

        // Reset: outputs forced low even with live inputs
        repeat (2) @(posedge clk);
        smp();
        chk("rst_enq_ready", 32'(enq_ready), 0);
        chk("rst_deq_valid", 32'(deq_valid), 0);
        chk("rst_in_valid",  32'(pifo_in_valid), 0);
        chk("rst_out_ready", 32'(pifo_out_ready), 0);
        chk("rst_deq_prio",  32'(deq_prio), 0);

        nxt(); reset = 1'b0; enq_valid = '0; env_model = 1'b1; deq_ready = 1'b0; sb_en = 1'b1;
        smp(); chk("idle_in_valid", 32'(pifo_in_valid), 0);

        // Ports 0,2,3 together: grants in round-robin order, pushes one cycle behind
        nxt(); enq_valid = 4'b1101;
        exp_push.push_back(16'h10A0); exp_push.push_back(16'h12A2); exp_push.push_back(16'h13A3);
        smp(); chk("rr_g0", 32'(enq_ready), 32'b0001); chk("rr_g0_push", 32'(pifo_in_valid), 0);
        nxt(); enq_valid = 4'b1100;
        smp(); chk("rr_g2", 32'(enq_ready), 32'b0100); chk("rr_g2_push", 32'(pifo_in_valid), 1);
        nxt(); enq_valid = 4'b1000;
        smp(); chk("rr_g3", 32'(enq_ready), 32'b1000); chk("rr_g3_push", 32'(pifo_in_valid), 1);
        nxt(); enq_valid = 4'b0000;
        smp(); chk("rr_none", 32'(enq_ready), 0); chk("rr_last_push", 32'(pifo_in_valid), 1);
        nxt(); enq_valid = 4'b1111;
        smp(); chk("rr_wrap", 32'(enq_ready), 32'b0001); chk("rr_wrap_nopush", 32'(pifo_in_valid), 0);

        // Clear with an entry held and a poppable head
        nxt(); clear_all = 1'b1; deq_ready = 1'b1;
        smp(); chk("clr_flag", 32'(pifo_clear), 1); chk("clr_grant", 32'(enq_ready), 0);
        chk("clr_push", 32'(pifo_in_valid), 0); chk("clr_pop", 32'(pifo_out_ready), 0);
        nxt(); clear_all = 1'b0; enq_valid = '0; deq_ready = 1'b0;
        smp(); chk("clr_hold_gone", 32'(pifo_in_valid), 0); chk("clr_flag_low", 32'(pifo_clear), 0);

        // Priorities 5,9,7 from ports 1,0,2: consumer sees 9,7,5
        nxt(); enq_valid = 4'b0010; p_prio[1] = 8'd5; p_data[1] = 8'h55;
        exp_push.push_back(16'h0555);
        smp(); chk("ord_g1", 32'(enq_ready), 32'b0010);
        nxt(); enq_valid = 4'b0001; p_prio[0] = 8'd9; p_data[0] = 8'h99;
        exp_push.push_back(16'h0999);
        smp(); chk("ord_g0", 32'(enq_ready), 32'b0001); chk("ord_push5", 32'(pifo_in_prio), 5);
        nxt(); enq_valid = 4'b0100; p_prio[2] = 8'd7; p_data[2] = 8'h77;
        exp_push.push_back(16'h0777);
        smp(); chk("ord_g2", 32'(enq_ready), 32'b0100); chk("ord_head_vis", 32'(deq_prio), 5);
        chk("ord_deq_blocked", 32'(deq_valid), 0);
        nxt(); enq_valid = '0;
        smp(); chk("ord_push7", 32'(pifo_in_valid), 1); chk("ord_deq_blocked2", 32'(deq_valid), 0);
        nxt(); deq_ready = 1'b1;
        exp_deq.push_back(16'h0999); exp_deq.push_back(16'h0777); exp_deq.push_back(16'h0555);
        smp(); chk("ord_pop9", 32'(deq_prio), 9); chk("ord_pop_rdy", 32'(pifo_out_ready), 1);
        nxt(); smp(); chk("ord_pop7", 32'(deq_prio), 7);
        nxt(); smp(); chk("ord_pop5", 32'(deq_prio), 5);
        nxt(); smp(); chk("ord_empty", 32'(deq_valid), 0);

        // Sustained contention after clear: 4 pushes, 4 pops, repeating
        nxt(); deq_ready = 1'b0; clear_all = 1'b1; sb_en = 1'b0;
        smp();
        nxt(); clear_all = 1'b0; env_model = 1'b0; drv_in_ready = 1'b1; drv_out_valid = 1'b0;
        deq_ready = 1'b1; enq_valid = 4'b1111;
        smp(); chk("burst_fill", 32'(pifo_in_valid), 0);
        for (int k = 0; k < 16; k++) begin
            nxt(); drv_out_valid = 1'b1;
            smp();
            chk($sformatf("burst_push[%0d]", k), 32'(pifo_in_valid), 32'(((k / 4) % 2) == 0));
            chk($sformatf("burst_pop[%0d]", k), 32'(pifo_out_ready), 32'(((k / 4) % 2) != 0));
        end
        nxt(); enq_valid = '0; drv_out_valid = 1'b0; deq_ready = 1'b0; clear_all = 1'b1;
        smp();
        nxt(); clear_all = 1'b0; sb_en = 1'b1;

        // PIFO full: hold retained, no grant, pop allowed in the enqueue turn
        enq_valid = 4'b0100; p_prio[2] = 8'h42; p_data[2] = 8'hC2;
        exp_push.push_back(16'h42C2);
        smp(); chk("full_g2", 32'(enq_ready), 32'b0100);
        nxt(); drv_in_ready = 1'b0; enq_valid = 4'b0011;
        p_prio[0] = 8'h30; p_data[0] = 8'hD0; p_prio[1] = 8'h31; p_data[1] = 8'hD1;
        drv_out_valid = 1'b1; drv_out_prio = 8'h66; drv_out_data = 8'hE6; deq_ready = 1'b1;
        exp_deq.push_back(16'h66E6);
        smp(); chk("full_no_grant", 32'(enq_ready), 0); chk("full_no_push", 32'(pifo_in_valid), 0);
        chk("full_hold_prio", 32'(pifo_in_prio), 32'h42); chk("full_pop", 32'(pifo_out_ready), 1);
        nxt(); drv_in_ready = 1'b1; drv_out_valid = 1'b0; deq_ready = 1'b0;
        smp(); chk("full_push_held", 32'(pifo_in_valid), 1); chk("full_regrant", 32'(enq_ready), 32'b0001);

        // Reset with an entry held: everything low, entry lost, pointer back at port 0
        nxt(); reset = 1'b1; enq_valid = 4'b1111; drv_out_valid = 1'b1; deq_ready = 1'b1;
        smp(); chk("mid_rst_grant", 32'(enq_ready), 0); chk("mid_rst_deq", 32'(deq_valid), 0);
        chk("mid_rst_push", 32'(pifo_in_valid), 0); chk("mid_rst_pop", 32'(pifo_out_ready), 0);
        nxt(); reset = 1'b0; enq_valid = '0; drv_out_valid = 1'b0; deq_ready = 1'b0;
        smp(); chk("post_rst_lost", 32'(pifo_in_valid), 0);
        nxt(); enq_valid = 4'b1111;
        exp_push.push_back(16'h30D0);
        smp(); chk("post_rst_rr0", 32'(enq_ready), 32'b0001);
        nxt(); enq_valid = '0;
        smp(); chk("post_rst_push", 32'(pifo_in_valid), 1);
        nxt(); smp(); chk("post_rst_idle", 32'(pifo_in_valid), 0);

        chk("push_queue_left", 32'(exp_push.size()), 0);
        chk("deq_queue_left", 32'(exp_deq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
